// File: rtl/pixel_writer_pkg.sv
// Shared screen geometry, pixel format and FSM encoding used by the line drawer,
// the pixel writer and the framebuffer controller.
package pixel_writer_pkg;

  localparam int DEF_H_RES = 640;
  localparam int DEF_V_RES = 480;
  localparam int COLOR_W   = 12;
  localparam int COORD_W   = 10;
  localparam int PIX_W     = COLOR_W + 2 * COORD_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } pw_state_e;

  typedef struct packed {
    logic [COLOR_W-1:0] color;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } pixel_t;

  function automatic logic pixelOnScreen(input pixel_t p, input int hRes, input int vRes);
    return (int'(p.x) < hRes) && (int'(p.y) < vRes);
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO holding pixels between the line drawer and the output register.
// The head entry is visible on data_o whenever the FIFO is non-empty.
module pixel_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [PTR_W:0]   count_q;
  logic             doPush, doPop;

  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rdPtr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/pixel_writer.sv
// Turns the line drawer's pixel stream into linear framebuffer writes, dropping
// off-screen pixels, and can fill the whole screen with one colour on request.
module pixel_writer
  import pixel_writer_pkg::*;
#(
  parameter int H_RES      = DEF_H_RES,
  parameter int V_RES      = DEF_V_RES,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 19
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [COORD_W-1:0]  pix_x,
  input  logic [COORD_W-1:0]  pix_y,
  input  logic [COLOR_W-1:0]  pix_color,
  input  logic                in_rts,
  output logic                in_rtr,
  input  logic [COLOR_W-1:0]  clear_color,
  input  logic                clear_rts,
  output logic                clear_rtr,
  output logic [ADDR_W-1:0]   fb_addr,
  output logic [COLOR_W-1:0]  fb_data,
  output logic                fb_rts,
  input  logic                fb_rtr,
  output logic                busy,
  output logic [15:0]         clip_count
);

  localparam int              CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  pw_state_e           state_q, state_d;
  logic                fbRts_q, fbRts_d;
  logic [ADDR_W-1:0]   fbAddr_q, fbAddr_d;
  logic [COLOR_W-1:0]  fbData_q, fbData_d;
  logic [15:0]         clipCnt_q, clipCnt_d;

  pixel_t              inPix, head;
  logic                fifoPush, fifoPop, fifoFull, fifoEmpty;
  logic [CNT_W-1:0]    fifoCount;
  logic                clearFire, outFree, headOnScreen;
  logic [ADDR_W-1:0]   headAddr;

  assign inPix = '{color: pix_color, y: pix_y, x: pix_x};

  pixel_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifoPush),
    .data_i  (inPix),
    .pop_i   (fifoPop),
    .data_o  (head),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  // A clear request beats a simultaneous pixel, so the pixel is refused this cycle.
  assign clear_rtr    = (state_q == IDLE) && fifoEmpty && !fbRts_q;
  assign clearFire    = clear_rts && clear_rtr;
  assign in_rtr       = (state_q == IDLE) && !fifoFull && !clearFire;
  assign fifoPush     = in_rts && in_rtr;
  assign outFree      = !fbRts_q || fb_rtr;
  assign headOnScreen = pixelOnScreen(head, H_RES, V_RES);
  assign headAddr     = ADDR_W'(head.y) * ADDR_W'(H_RES) + ADDR_W'(head.x);

  always_comb begin
    state_d   = state_q;
    fbRts_d   = fbRts_q;
    fbAddr_d  = fbAddr_q;
    fbData_d  = fbData_q;
    clipCnt_d = clipCnt_q;
    fifoPop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (clearFire) begin
          state_d  = CLEAR;
          fbRts_d  = 1'b1;
          fbAddr_d = '0;
          fbData_d = clear_color;
        end else if (outFree) begin
          fbRts_d = 1'b0;
          if (!fifoEmpty) begin
            fifoPop = 1'b1;
            if (headOnScreen) begin
              fbRts_d  = 1'b1;
              fbAddr_d = headAddr;
              fbData_d = head.color;
            end else if (clipCnt_q != 16'hFFFF) begin
              clipCnt_d = clipCnt_q + 16'd1;
            end
          end
        end
      end
      CLEAR: begin
        // fbAddr_q doubles as the fill counter; fbData_q holds the latched colour.
        if (fb_rtr) begin
          if (fbAddr_q == LAST_ADDR) begin
            state_d = IDLE;
            fbRts_d = 1'b0;
          end else begin
            fbAddr_d = fbAddr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      fbRts_q   <= 1'b0;
      fbAddr_q  <= '0;
      fbData_q  <= '0;
      clipCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      fbRts_q   <= fbRts_d;
      fbAddr_q  <= fbAddr_d;
      fbData_q  <= fbData_d;
      clipCnt_q <= clipCnt_d;
    end
  end

  assign fb_rts     = fbRts_q;
  assign fb_addr    = fbAddr_q;
  assign fb_data    = fbData_q;
  assign clip_count = clipCnt_q;
  assign busy       = (fifoCount != '0) || fbRts_q || (state_q == CLEAR);

endmodule
